note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_sequencer_if.sv | 19 +
 rtl/note_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_note_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// Pattern write bus for note_sequencer: one-cycle write strobe with a registered acknowledge.
interface note_sequencer_if;
  logic       WR_EN;
  logic [3:0] WR_ADDR;
  logic [7:0] WR_NOTE;
  logic [2:0] WR_FORM;
  logic       WR_REST;
  logic       WR_ACK;

  modport master (
    output WR_EN, WR_ADDR, WR_NOTE, WR_FORM, WR_REST,
    input  WR_ACK
  );

  modport slave (
    input  WR_EN, WR_ADDR, WR_NOTE, WR_FORM, WR_REST,
    output WR_ACK
  );
endinterface

// File: rtl/note_sequencer.sv
// 16-step pattern sequencer feeding note, waveform and gate to a synth voice.
// Optional ping-pong traversal is built when SEQ_PINGPONG_EN is defined.
module note_sequencer #(
  parameter int TEMPO_W   = 24,
  parameter int INIT_NOTE = 69
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               RUN,
  input  logic [TEMPO_W-1:0] TEMPO,
  input  logic [TEMPO_W-1:0] GATE_LEN,
  input  logic [3:0]         LAST_STEP,
  input  logic               PP_MODE,
  note_sequencer_if.slave    wr,
  output logic [7:0]         NOTE,
  output logic [2:0]         FORM,
  output logic               GATE,
  output logic [3:0]         STEP,
  output logic               STEP_STB
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_ON  = 2'd1,
    GATE_OFF = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] note;
    logic [2:0] form;
    logic       rest;
  } entry_t;

  localparam entry_t             RESET_ENTRY = '{note: 8'(INIT_NOTE), form: 3'd0, rest: 1'b0};
  localparam logic [TEMPO_W-1:0] TICK_ONE    = TEMPO_W'(1);
  localparam logic [TEMPO_W:0]   TICK_ONE_X  = (TEMPO_W + 1)'(1);

  entry_t             pattern [16];
  entry_t             load_entry;
  state_t             state_q, state_d;
  logic [TEMPO_W-1:0] tick_q, tick_d;
  logic [TEMPO_W:0]   tick_inc;
  logic [3:0]         step_d, next_idx, load_idx;
  logic [7:0]         note_d;
  logic [2:0]         form_d;
  logic               gate_d, stb_d, load, step_adv;

  // NOTE: the pattern lives in flops, not a RAM macro, because every entry must
  // return to its default while reset is held.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 16; i++) pattern[i] <= RESET_ENTRY;
      wr.WR_ACK <= 1'b0;
    end else begin
      wr.WR_ACK <= wr.WR_EN;
      if (wr.WR_EN)
        pattern[wr.WR_ADDR] <= '{note: wr.WR_NOTE, form: wr.WR_FORM, rest: wr.WR_REST};
    end
  end

  assign step_adv = (state_q != IDLE) && RUN && (tick_q >= TEMPO);
  assign tick_inc = {1'b0, tick_q} + TICK_ONE_X;

`ifdef SEQ_PINGPONG_EN
  logic dir_rev_q, dir_rev_d, dir_rev_nxt;

  // Endpoints are played once per turn: the turn happens on leaving them.
  always_comb begin
    next_idx    = 4'd0;
    dir_rev_nxt = dir_rev_q;
    if (!PP_MODE) begin
      dir_rev_nxt = 1'b0;
      next_idx    = (STEP >= LAST_STEP) ? 4'd0 : STEP + 4'd1;
    end else if (!dir_rev_q) begin
      if (STEP < LAST_STEP) begin
        next_idx = STEP + 4'd1;
      end else if (LAST_STEP != 4'd0) begin
        next_idx    = LAST_STEP - 4'd1;
        dir_rev_nxt = 1'b1;
      end
    end else begin
      if (STEP > LAST_STEP) begin
        next_idx = LAST_STEP;
      end else if (STEP != 4'd0) begin
        next_idx = STEP - 4'd1;
      end else begin
        dir_rev_nxt = 1'b0;
        next_idx    = (LAST_STEP == 4'd0) ? 4'd0 : 4'd1;
      end
    end
  end

  always_comb begin
    dir_rev_d = PP_MODE ? dir_rev_q : 1'b0;
    if (state_q == IDLE || !RUN) dir_rev_d = 1'b0;
    else if (step_adv)           dir_rev_d = dir_rev_nxt;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) dir_rev_q <= 1'b0;
    else          dir_rev_q <= dir_rev_d;
  end
`else
  logic unused_pp_mode;
  assign unused_pp_mode = PP_MODE;

  // A lowered LAST_STEP that strands STEP above it also wraps to 0.
  always_comb next_idx = (STEP >= LAST_STEP) ? 4'd0 : STEP + 4'd1;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    step_d   = STEP;
    note_d   = NOTE;
    form_d   = FORM;
    gate_d   = GATE;
    stb_d    = 1'b0;
    load     = 1'b0;
    load_idx = next_idx;

    case (state_q)
      IDLE: begin
        tick_d = '0;
        step_d = 4'd0;
        gate_d = 1'b0;
        if (RUN) begin
          load     = 1'b1;
          load_idx = 4'd0;
        end
      end
      default: begin
        if (!RUN) begin
          state_d = IDLE;
          tick_d  = '0;
          step_d  = 4'd0;
          gate_d  = 1'b0;
        end else if (step_adv) begin
          load = 1'b1;
        end else begin
          tick_d = tick_q + TICK_ONE;
          if (state_q == GATE_ON && tick_inc >= {1'b0, GATE_LEN}) begin
            state_d = GATE_OFF;
            gate_d  = 1'b0;
          end
        end
      end
    endcase

    // The memory read happens before this edge's write lands, so a coincident
    // write to the loaded address is seen only on the next visit.
    load_entry = pattern[load_idx];
    if (load) begin
      tick_d = '0;
      step_d = load_idx;
      stb_d  = 1'b1;
      if (!load_entry.rest) begin
        note_d = load_entry.note;
        form_d = load_entry.form;
      end
      if (!load_entry.rest && GATE_LEN != '0) begin
        state_d = GATE_ON;
        gate_d  = 1'b1;
      end else begin
        state_d = GATE_OFF;
        gate_d  = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      STEP     <= 4'd0;
      NOTE     <= 8'(INIT_NOTE);
      FORM     <= 3'd0;
      GATE     <= 1'b0;
      STEP_STB <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      STEP     <= step_d;
      NOTE     <= note_d;
      FORM     <= form_d;
      GATE     <= gate_d;
      STEP_STB <= stb_d;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed scenarios plus randomized runs,
// compared every clock against a closed-form step/gate model of the pattern player.
module tb_note_sequencer;
  localparam int TW = 24;

`ifdef SEQ_PINGPONG_EN
  localparam bit PP_EN = 1'b1;
`else
  localparam bit PP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          run = 1'b0;
  logic [TW-1:0] tempo = '0;
  logic [TW-1:0] gate_len = '0;
  logic [3:0]    last_step = '0;
  logic          pp_mode = 1'b0;
  logic [7:0]    note;
  logic [2:0]    form;
  logic          gate;
  logic [3:0]    step;
  logic          step_stb;

  note_sequencer_if wr_if ();

  note_sequencer #(.TEMPO_W(TW), .INIT_NOTE(69)) dut (
    .CLK      (clk),
    .RESET_N  (rst_n),
    .RUN      (run),
    .TEMPO    (tempo),
    .GATE_LEN (gate_len),
    .LAST_STEP(last_step),
    .PP_MODE  (pp_mode),
    .wr       (wr_if),
    .NOTE     (note),
    .FORM     (form),
    .GATE     (gate),
    .STEP     (step),
    .STEP_STB (step_stb)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "reset";

  // Reference model: the pattern as written, the run-relative clock count, and the held voice.
  int m_note [16];
  int m_form [16];
  bit m_rest [16];
  int exp_note, exp_form;
  bit cur_rest;
  int k;
  bit was_running;
  bit pend;
  int pend_addr, pend_note, pend_form;
  bit pend_rest;

  task automatic check(input string field, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s.%s: observed %0d expected %0d", phase, field, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_note[i] = 69;
      m_form[i] = 0;
      m_rest[i] = 1'b0;
    end
    exp_note    = 69;
    exp_form    = 0;
    cur_rest    = 1'b0;
    k           = 0;
    was_running = 1'b0;
    pend        = 1'b0;
  endtask

  // Step index of the n-th step load after RUN rises.
  function automatic int seq_index(input int n, input int l, input bit pp);
    int m;
    if (pp && PP_EN && l > 0) begin
      m = n % (2 * l);
      return (m <= l) ? m : 2 * l - m;
    end
    return n % (l + 1);
  endfunction

  task automatic write_entry(input int addr, input int nt, input int fm, input bit rs);
    wr_if.WR_EN   = 1'b1;
    wr_if.WR_ADDR = 4'(addr);
    wr_if.WR_NOTE = 8'(nt);
    wr_if.WR_FORM = 3'(fm);
    wr_if.WR_REST = rs;
    pend      = 1'b1;
    pend_addr = addr;
    pend_note = nt;
    pend_form = fm;
    pend_rest = rs;
  endtask

  // One clock: predict the post-edge outputs, compare, then retire any write.
  task automatic edge_check();
    int per, n, p, s, e_step, e_gate, e_stb, e_ack;
    @(posedge clk);
    #1;
    e_ack = pend ? 1 : 0;
    if (run) begin
      if (!was_running) k = 0;
      per = int'(tempo) + 1;
      n   = k / per;
      p   = k % per;
      s   = seq_index(n, int'(last_step), pp_mode);
      if (p == 0) begin
        cur_rest = m_rest[s];
        if (!cur_rest) begin
          exp_note = m_note[s];
          exp_form = m_form[s];
        end
      end
      e_step = s;
      e_stb  = (p == 0) ? 1 : 0;
      e_gate = (!cur_rest && p < int'(gate_len)) ? 1 : 0;
      k++;
    end else begin
      e_step = 0;
      e_stb  = 0;
      e_gate = 0;
    end
    was_running = run;
    if (pend) begin
      m_note[pend_addr] = pend_note;
      m_form[pend_addr] = pend_form;
      m_rest[pend_addr] = pend_rest;
      pend = 1'b0;
    end
    check("step",   32'(step),         32'(e_step));
    check("stb",    32'(step_stb),     32'(e_stb));
    check("gate",   32'(gate),         32'(e_gate));
    check("note",   32'(note),         32'(exp_note));
    check("form",   32'(form),         32'(exp_form));
    check("wr_ack", 32'(wr_if.WR_ACK), 32'(e_ack));
    wr_if.WR_EN = 1'b0;
  endtask

  task automatic play(input int cycles);
    run = 1'b1;
    for (int i = 0; i < cycles; i++) edge_check();
  endtask

  task automatic stop();
    run = 1'b0;
    edge_check();
    edge_check();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    wr_if.WR_EN   = 1'b0;
    wr_if.WR_ADDR = '0;
    wr_if.WR_NOTE = '0;
    wr_if.WR_FORM = '0;
    wr_if.WR_REST = 1'b0;
    model_reset();

    // Reset values appear without any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_step", 32'(step),         32'd0);
    check("rst_note", 32'(note),         32'd69);
    check("rst_form", 32'(form),         32'd0);
    check("rst_gate", 32'(gate),         32'd0);
    check("rst_stb",  32'(step_stb),     32'd0);
    check("rst_ack",  32'(wr_if.WR_ACK), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    edge_check();

    // Basic forward play, half-length gate.
    phase = "forward";
    tempo = 9; gate_len = 5; last_step = 3; pp_mode = 1'b0;
    play(45);
    stop();

    // Rest on step 2 holds step-1 voice with gate low.
    phase = "rest";
    write_entry(0, 50, 1, 1'b0); edge_check();
    write_entry(1, 55, 4, 1'b0); edge_check();
    write_entry(2, 60, 2, 1'b1); edge_check();
    write_entry(3, 64, 3, 1'b0); edge_check();
    play(45);
    stop();

    // Rewriting the playing entry takes effect only on the next visit.
    phase = "rewrite";
    write_entry(2, 62, 2, 1'b0); edge_check();
    run = 1'b1;
    for (int i = 0; i < 55; i++) begin
      if (i == 13) write_entry(1, 72, 3, 1'b0);
      edge_check();
    end
    stop();

    // Legato: gate never drops while running, then clears on stop.
    phase = "legato";
    tempo = 9; gate_len = 20;
    play(35);
    stop();

    // Ping-pong walk (forward only when the feature is not built).
    phase = "pingpong";
    tempo = 3; gate_len = 2; last_step = 3; pp_mode = 1'b1;
    play(40);
    stop();

    // Single-step pattern replays step 0 every period.
    phase = "single";
    tempo = 2; gate_len = 1; last_step = 0; pp_mode = 1'b0;
    play(12);
    stop();

    // Randomized runs with mid-run writes, including same-address collisions.
    phase = "random";
    for (int r = 0; r < 8; r++) begin
      tempo     = TW'($urandom_range(0, 6));
      gate_len  = TW'($urandom_range(0, 9));
      last_step = 4'($urandom_range(0, 15));
      pp_mode   = 1'($urandom_range(0, 1));
      run = 1'b1;
      for (int i = 0; i < 70; i++) begin
        if ($urandom_range(0, 5) == 0)
          write_entry(int'($urandom_range(0, 15)), int'($urandom_range(0, 127)),
                      int'($urandom_range(0, 4)), 1'($urandom_range(0, 3) == 0));
        edge_check();
      end
      stop();
    end

    // Reset mid-step 2 aborts at once and restores the pattern.
    phase = "midreset";
    tempo = 9; gate_len = 5; last_step = 3; pp_mode = 1'b0;
    play(25);
    rst_n = 1'b0;
    #1;
    check("abort_step", 32'(step), 32'd0);
    check("abort_gate", 32'(gate), 32'd0);
    check("abort_note", 32'(note), 32'd69);
    check("abort_form", 32'(form), 32'd0);
    model_reset();
    run = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    edge_check();
    tempo = 3; gate_len = 2; last_step = 15;
    play(64);
    stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
